// File: rtl/datapath_pkg.sv
// Shared encodings for the datapath register bank and the control unit that drives it.
package datapath_pkg;

  localparam int NUM_REGS = 13;
  localparam int NUM_SRC  = 16;

  // bus_ld source select
  localparam logic [3:0] BUS_IMEM = 4'd0;
  localparam logic [3:0] BUS_DMEM = 4'd1;
  localparam logic [3:0] BUS_PC   = 4'd2;
  localparam logic [3:0] BUS_DR   = 4'd3;
  localparam logic [3:0] BUS_R    = 4'd4;
  localparam logic [3:0] BUS_AC   = 4'd5;
  localparam logic [3:0] BUS_TR   = 4'd6;
  localparam logic [3:0] BUS_R1   = 4'd7;
  localparam logic [3:0] BUS_R2   = 4'd8;
  localparam logic [3:0] BUS_RI   = 4'd9;
  localparam logic [3:0] BUS_RJ   = 4'd10;
  localparam logic [3:0] BUS_RK   = 4'd11;

  // write_en bit positions
  localparam int WE_RK  = 0;
  localparam int WE_RJ  = 1;
  localparam int WE_RI  = 2;
  localparam int WE_R2  = 3;
  localparam int WE_R1  = 4;
  localparam int WE_AC  = 5;
  localparam int WE_TR  = 6;
  localparam int WE_R   = 7;
  localparam int WE_IR  = 8;
  localparam int WE_DR  = 9;
  localparam int WE_PC  = 10;
  localparam int WE_AR  = 11;
  localparam int WE_ARB = 12;

  // alu_mode[2:0]; every undecoded value behaves as ALU_PASS
  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_MUL  = 3'b010;
  localparam logic [2:0] ALU_PASS = 3'b101;

  localparam logic [1:0] INC_PC = 2'b01;
  localparam logic [1:0] INC_AC = 2'b10;

  // clr bit positions
  localparam int CLR_PC = 0;
  localparam int CLR_TR = 1;
  localparam int CLR_AC = 2;

endpackage

// File: rtl/bus_mux.sv
// Combinational 16:1 shared-bus source select.
module bus_mux #(
  parameter int DATA_W  = 8,
  parameter int NUM_SRC = 16
) (
  input  logic [NUM_SRC-1:0][DATA_W-1:0] src,
  input  logic [$clog2(NUM_SRC)-1:0]     sel,
  output logic [DATA_W-1:0]              bus
);

  assign bus = src[sel];

endmodule

// File: rtl/datapath_regbank.sv
// Architectural register bank, ALU and shared bus. Optional run-length counter
// is built only when DATAPATH_PERF_CNT_EN is defined.
module datapath_regbank
  import datapath_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [12:0]          write_en,
  input  logic [3:0]           bus_ld,
  input  logic [1:0]           inc,
  input  logic [2:0]           clr,
  input  logic [3:0]           alu_mode,
  input  logic                 dm_wr,
  input  logic                 im_wr,
  input  logic                 end_op,
  input  logic [DATA_W-1:0]    im_rdata,
  input  logic [DATA_W-1:0]    dm_rdata,
  output logic [ADDR_W-1:0]    im_addr,
  output logic [ADDR_W-1:0]    dm_addr,
  output logic [DATA_W-1:0]    im_wdata,
  output logic [DATA_W-1:0]    dm_wdata,
  output logic                 im_we,
  output logic                 dm_we,
  output logic [7:0]           ir,
  output logic                 z,
  output logic                 done,
  output logic [15:0]          cycle_cnt
);

  logic [ADDR_W-1:0] arb_q, ar_q, pc_q;
  logic [DATA_W-1:0] dr_q, ir_q, r_q, tr_q, ac_q;
  // R1, R2, Ri, Rj, Rk share write_en bits 4..0, so gpr[i] pairs with write_en[i]
  logic [4:0][DATA_W-1:0] gpr_q;
  logic [NUM_SRC-1:0][DATA_W-1:0] src;
  logic [DATA_W-1:0] bus, alu_res;
  logic done_q;
  logic unused_alu_mode;

  assign unused_alu_mode = alu_mode[3];

  always_comb begin
    src           = '0;
    src[BUS_IMEM] = im_rdata;
    src[BUS_DMEM] = dm_rdata;
    src[BUS_PC]   = DATA_W'(pc_q);
    src[BUS_DR]   = dr_q;
    src[BUS_R]    = r_q;
    src[BUS_AC]   = ac_q;
    src[BUS_TR]   = tr_q;
    src[BUS_R1]   = gpr_q[WE_R1];
    src[BUS_R2]   = gpr_q[WE_R2];
    src[BUS_RI]   = gpr_q[WE_RI];
    src[BUS_RJ]   = gpr_q[WE_RJ];
    src[BUS_RK]   = gpr_q[WE_RK];
  end

  bus_mux #(.DATA_W(DATA_W), .NUM_SRC(NUM_SRC)) u_bus_mux (
    .src (src),
    .sel (bus_ld),
    .bus (bus)
  );

  always_comb begin
    case (alu_mode[2:0])
      ALU_ADD: alu_res = ac_q + bus;
      ALU_SUB: alu_res = ac_q - bus;
      ALU_MUL: alu_res = ac_q * bus;
      default: alu_res = bus;
    endcase
  end

  // Priority per register: rst > clr > write_en > inc
  always_ff @(posedge clk) begin
    if (rst) begin
      arb_q <= '0;
      ar_q  <= '0;
      pc_q  <= '0;
      dr_q  <= '0;
      ir_q  <= '0;
      r_q   <= '0;
      tr_q  <= '0;
      ac_q  <= '0;
    end else begin
      if (write_en[WE_ARB]) arb_q <= ADDR_W'(bus);
      if (write_en[WE_AR])  ar_q  <= ADDR_W'(bus);
      if (write_en[WE_DR])  dr_q  <= bus;
      if (write_en[WE_IR])  ir_q  <= bus;
      if (write_en[WE_R])   r_q   <= bus;

      if (clr[CLR_PC])          pc_q <= '0;
      else if (write_en[WE_PC]) pc_q <= ADDR_W'(bus);
      else if (inc == INC_PC)   pc_q <= pc_q + 1'b1;

      if (clr[CLR_TR])          tr_q <= '0;
      else if (write_en[WE_TR]) tr_q <= bus;

      if (clr[CLR_AC])          ac_q <= '0;
      else if (write_en[WE_AC]) ac_q <= alu_res;
      else if (inc == INC_AC)   ac_q <= ac_q + 1'b1;
    end
  end

  for (genvar i = 0; i < 5; i++) begin : g_gpr
    always_ff @(posedge clk) begin
      if (rst)              gpr_q[i] <= '0;
      else if (write_en[i]) gpr_q[i] <= bus;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)         done_q <= 1'b0;
    else if (end_op) done_q <= 1'b1;
  end

`ifdef DATAPATH_PERF_CNT_EN
  logic [15:0] cnt_q;
  // Counts through the end_op edge itself, then holds; saturates rather than wraps
  always_ff @(posedge clk) begin
    if (rst)                              cnt_q <= '0;
    else if (!done_q && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
  end
  assign cycle_cnt = cnt_q;
`else
  assign cycle_cnt = '0;
`endif

  assign im_addr  = ar_q;
  assign dm_addr  = arb_q;
  assign im_wdata = bus;
  assign dm_wdata = bus;
  assign im_we    = im_wr;
  assign dm_we    = dm_wr;
  assign ir       = ir_q[7:0];
  assign z        = (ac_q == '0);
  assign done     = done_q;

endmodule
